mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- FSM that sequences every RAM transaction of the DataPath2 datapath: instruction fetch into IR, loads into MDR, and stores from MDR.
- Arbitrates between the fetch requester and the load/store requester (both from the main control unit).
- Drives the MAR/MDR/IR enables, MDR_Mux_select, RAM_enable and RAM_OpCode, and waits on the RAM MFC handshake.
- Checks alignment, enforces a timeout and reports completion or fault back to the control unit.

Parameters:
- TIMEOUT_CYC, 16: maximum cycles spent in ACCESS waiting for MFC before a timeout fault. Legal range 1..255.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Clr  in  1  asynchronous, active-high reset.
- req_fetch  in  1  fetch request; level, held until done_o or fault_o.
- req_ls  in  1  load/store request; level, held until done_o or fault_o.
- ls_op3  in  6  SPARC op3 of the load/store; sampled at grant.
- addr_lo  in  2  ALU_out[1:0] (the address being written to MAR); sampled in state MAR.
- MFC  in  1  RAM memory-function-complete.
- grant_fetch  out  1  fetch owns the ALU/address path (states MAR..DONE).
- grant_ls  out  1  load/store owns the ALU/address path (states MAR..DONE).
- MAR_Enable  out  1  MAR load.
- MDR_Enable  out  1  MDR load.
- MDR_Mux_select  out  1  0 = ALU_out, 1 = RAM_Out.
- IR_Enable  out  1  IR load.
- RAM_enable  out  1  RAM strobe.
- RAM_OpCode  out  6  op3 presented to the RAM.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle completion pulse.
- fault_o  out  1  one-cycle fault pulse.
- fault_code  out  2  01 = misaligned, 10 = timeout, 11 = illegal op3; holds until the next grant.

Behaviour:
- Reset (async, Clr=1): state IDLE; all outputs 0; timeout counter 0; latched op 0.
- States: IDLE, MAR, MDR, ACCESS, CAPTURE, DONE, FAULT.
- IDLE:
  - req_ls=1 → grant to ls; latch ls_op3. A simultaneous req_fetch waits.
  - Otherwise req_fetch=1 → grant to fetch; latch op 000000 (LD word).
  - Next state MAR.
- Illegal op3: if the latched op3 is not one of 000000, 000001, 000010, 001001, 001010, 000100, 000101, 000110, go IDLE→FAULT with code 11. No MAR load occurs.
- MAR: MAR_Enable=1; sample addr_lo.
  - Alignment rule: word ops need addr_lo=00; halfword ops (000010, 001010, 000110) need addr_lo[0]=0; byte ops have no constraint.
  - Misaligned → FAULT, code 01. MAR is already loaded; harmless.
  - Aligned store (op3[2]=1) → MDR. Aligned fetch or load → ACCESS.
- MDR (stores only): MDR_Enable=1, MDR_Mux_select=0. Next ACCESS.
- ACCESS: RAM_enable=1, RAM_OpCode=latched op. Counter increments each cycle.
  - MFC=1 → CAPTURE (fetch/load) or DONE (store). Counter cleared.
  - Counter reaching TIMEOUT_CYC with MFC=0 → FAULT, code 10.
  - MFC arriving on the same cycle the counter expires → success wins.
- CAPTURE: RAM_enable stays 1.
  - Fetch: IR_Enable=1.
  - Load: MDR_Enable=1 and MDR_Mux_select=1.
  - Next DONE.
- DONE: done_o=1 for one cycle, RAM_enable=0; next IDLE. A new request is accepted no earlier than the following cycle.
- FAULT: fault_o=1 for one cycle, all enables 0; next IDLE.
- Grants and busy_o:
  - grant_* are asserted from MAR through DONE/FAULT inclusive; never both at once.
  - busy_o=1 in every state except IDLE.
- Requester rules:
  - A requester that drops its request mid-transaction is ignored; the transaction completes.
  - Requests are sampled only in IDLE.
- Clr mid-transaction: immediately returns to IDLE with all outputs 0; no done_o or fault_o pulse.
- Outputs are Moore, decoded from state plus latched op/owner. No combinational path from MFC to any output.
- Latency, zero-wait RAM (MFC=1 in the first ACCESS cycle), grant→done_o: fetch/load 4 cycles (MAR, ACCESS, CAPTURE, DONE); store 4 cycles (MAR, MDR, ACCESS, DONE).

Decomposition:
- Shared package mem_seq_pkg holds:
  - State encoding (3-bit).
  - Op3 constants OP_LD=000000, OP_LDUB=000001, OP_LDUH=000010, OP_LDSB=001001, OP_LDSH=001010, OP_ST=000100, OP_STB=000101, OP_STH=000110.
  - Fault codes FLT_NONE=00, FLT_ALIGN=01, FLT_TMO=10, FLT_OP=11.
- One sub-module, mem_align_check: combinational (op3, addr_lo) → {legal, aligned, is_store}. It is reused later by the trap logic.

Test Plan:
- Fetch, MFC on the first ACCESS cycle: req_fetch=1 → MAR_Enable at cycle 1, RAM_enable/RAM_OpCode=000000 at cycle 2, IR_Enable at cycle 3, done_o at cycle 4, busy_o low at cycle 5.
- Store STH, addr_lo=10, MFC after 3 wait cycles: sequence MAR→MDR (MDR_Mux_select=0)→ACCESS for 4 cycles with RAM_OpCode=000110 → done_o; IR_Enable never asserted.
- Simultaneous req_fetch and req_ls(LDUB, addr_lo=11): grant_ls first; load completes with MDR_Enable and MDR_Mux_select=1; then grant_fetch on the cycle after IDLE.
- Misalignment and illegal op: LD with addr_lo=01 → fault_o with fault_code=01 one cycle after MAR, no RAM_enable. ls_op3=000011 → fault_code=11, MAR_Enable never asserted.
- Timeout, TIMEOUT_CYC=4, MFC held 0: RAM_enable high exactly 4 cycles → fault_o with code 10. Repeat with MFC=1 on the 4th cycle → done path, no fault.
- Clr asserted mid-ACCESS: all outputs 0 asynchronously, state IDLE, no done_o/fault_o. After release, a held req_fetch restarts from MAR.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared state encoding, SPARC load/store op3 values and fault codes for the
// memory access sequencer and its alignment checker.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MAR     = 3'd1,
    ST_MDR     = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_e;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_ALIGN = 2'b01;
  localparam logic [1:0] FLT_TMO   = 2'b10;
  localparam logic [1:0] FLT_OP    = 2'b11;

endpackage

// File: rtl/mem_align_check.sv
// Combinational classifier for a load/store op3: legality, address alignment
// against the low address bits, and store direction.
module mem_align_check
  import mem_seq_pkg::*;
(
  input  logic [5:0] op3_i,
  input  logic [1:0] addr_lo_i,
  output logic       legal_o,
  output logic       aligned_o,
  output logic       is_store_o
);

  // Access width decides the alignment constraint; unknown op3 is never aligned.
  always_comb begin
    legal_o   = 1'b0;
    aligned_o = 1'b0;
    case (op3_i)
      OP_LD, OP_ST: begin
        legal_o   = 1'b1;
        aligned_o = (addr_lo_i == 2'b00);
      end
      OP_LDUH, OP_LDSH, OP_STH: begin
        legal_o   = 1'b1;
        aligned_o = (addr_lo_i[0] == 1'b0);
      end
      OP_LDUB, OP_LDSB, OP_STB: begin
        legal_o   = 1'b1;
        aligned_o = 1'b1;
      end
      default: begin
        legal_o   = 1'b0;
        aligned_o = 1'b0;
      end
    endcase
  end

  assign is_store_o = op3_i[2];

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences instruction fetches, loads and stores through MAR/MDR/IR and the
// RAM MFC handshake, with fetch vs load/store arbitration and fault reporting.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       req_fetch,
  input  logic       req_ls,
  input  logic [5:0] ls_op3,
  input  logic [1:0] addr_lo,
  input  logic       MFC,
  output logic       grant_fetch,
  output logic       grant_ls,
  output logic       MAR_Enable,
  output logic       MDR_Enable,
  output logic       MDR_Mux_select,
  output logic       IR_Enable,
  output logic       RAM_enable,
  output logic [5:0] RAM_OpCode,
  output logic       busy_o,
  output logic       done_o,
  output logic       fault_o,
  output logic [1:0] fault_code
);

  localparam logic [8:0] TMO_LIM = 9'(TIMEOUT_CYC);

  state_e     state_q, state_d;
  logic       owner_ls_q, owner_ls_d;
  logic [5:0] op_q, op_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] fcode_q, fcode_d;
  logic [5:0] chk_op_s;
  logic       chk_legal_s, chk_aligned_s, chk_store_s;
  logic [8:0] cnt_inc_s;

  logic       run_s;
  logic       gnt_f_d, gnt_l_d, mar_en_d, mdr_en_d, mdr_sel_d, ir_en_d, ram_en_d;
  logic       done_d, fault_d;
  logic [5:0] ram_op_d;
  logic       gnt_f_q, gnt_l_q, mar_en_q, mdr_en_q, mdr_sel_q, ir_en_q, ram_en_q;
  logic       busy_q, done_q, fault_q;
  logic [5:0] ram_op_q;

  // In IDLE the checker judges the op about to be granted, otherwise the latched one.
  always_comb begin
    if (state_q == ST_IDLE) begin
      chk_op_s = req_ls ? ls_op3 : OP_LD;
    end else begin
      chk_op_s = op_q;
    end
  end

  mem_align_check u_align (
    .op3_i      (chk_op_s),
    .addr_lo_i  (addr_lo),
    .legal_o    (chk_legal_s),
    .aligned_o  (chk_aligned_s),
    .is_store_o (chk_store_s)
  );

  assign cnt_inc_s = {1'b0, cnt_q} + 9'd1;

  // Next-state logic: arbitration, alignment/timeout faults and the RAM handshake.
  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    fcode_d    = fcode_q;
    case (state_q)
      ST_IDLE: begin
        if (req_ls || req_fetch) begin
          owner_ls_d = req_ls;
          op_d       = chk_op_s;
          if (chk_legal_s) begin
            state_d = ST_MAR;
            fcode_d = FLT_NONE;
          end else begin
            state_d = ST_FAULT;
            fcode_d = FLT_OP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAR: begin
        if (!chk_aligned_s) begin
          state_d = ST_FAULT;
          fcode_d = FLT_ALIGN;
        end else if (chk_store_s) begin
          state_d = ST_MDR;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_MDR:     state_d = ST_ACCESS;
      ST_ACCESS: begin
        // MFC is tested first so a completion on the expiry cycle still succeeds.
        if (MFC) begin
          cnt_d   = 8'd0;
          state_d = chk_store_s ? ST_DONE : ST_CAPTURE;
        end else if (cnt_inc_s >= TMO_LIM) begin
          cnt_d   = 8'd0;
          state_d = ST_FAULT;
          fcode_d = FLT_TMO;
        end else begin
          cnt_d = cnt_inc_s[7:0];
        end
      end
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      ST_FAULT:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state.
  always_comb begin
    run_s     = (state_d != ST_IDLE);
    gnt_f_d   = run_s && !owner_ls_d;
    gnt_l_d   = run_s && owner_ls_d;
    mar_en_d  = (state_d == ST_MAR);
    mdr_en_d  = (state_d == ST_MDR) || ((state_d == ST_CAPTURE) && owner_ls_d);
    mdr_sel_d = (state_d == ST_CAPTURE) && owner_ls_d;
    ir_en_d   = (state_d == ST_CAPTURE) && !owner_ls_d;
    ram_en_d  = (state_d == ST_ACCESS) || (state_d == ST_CAPTURE);
    ram_op_d  = ram_en_d ? op_d : 6'd0;
    done_d    = (state_d == ST_DONE);
    fault_d   = (state_d == ST_FAULT);
  end

  // State, latched transaction context and registered outputs.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q    <= ST_IDLE;
      owner_ls_q <= 1'b0;
      op_q       <= 6'd0;
      cnt_q      <= 8'd0;
      fcode_q    <= FLT_NONE;
      gnt_f_q    <= 1'b0;
      gnt_l_q    <= 1'b0;
      mar_en_q   <= 1'b0;
      mdr_en_q   <= 1'b0;
      mdr_sel_q  <= 1'b0;
      ir_en_q    <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_op_q   <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      fcode_q    <= fcode_d;
      gnt_f_q    <= gnt_f_d;
      gnt_l_q    <= gnt_l_d;
      mar_en_q   <= mar_en_d;
      mdr_en_q   <= mdr_en_d;
      mdr_sel_q  <= mdr_sel_d;
      ir_en_q    <= ir_en_d;
      ram_en_q   <= ram_en_d;
      ram_op_q   <= ram_op_d;
      busy_q     <= run_s;
      done_q     <= done_d;
      fault_q    <= fault_d;
    end
  end

  assign grant_fetch    = gnt_f_q;
  assign grant_ls       = gnt_l_q;
  assign MAR_Enable     = mar_en_q;
  assign MDR_Enable     = mdr_en_q;
  assign MDR_Mux_select = mdr_sel_q;
  assign IR_Enable      = ir_en_q;
  assign RAM_enable     = ram_en_q;
  assign RAM_OpCode     = ram_op_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign fault_o        = fault_q;
  assign fault_code     = fcode_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized scoreboard bench: a transaction-level model predicts outcome,
// latency and strobe activity; a monitor compares each done/fault completion.
module tb_mem_access_sequencer;

  localparam int TMO = 4;

  logic       Clk = 1'b0;
  logic       Clr, req_fetch, req_ls, MFC;
  logic [5:0] ls_op3;
  logic [1:0] addr_lo;
  logic       grant_fetch, grant_ls, MAR_Enable, MDR_Enable, MDR_Mux_select;
  logic       IR_Enable, RAM_enable, busy_o, done_o, fault_o;
  logic [5:0] RAM_OpCode;
  logic [1:0] fault_code;
  logic [17:0] all_outs;

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit         ls;
    logic [5:0] op;
    logic [1:0] addr;
    int         wt;
    bit         drop;
  } txn_t;

  typedef struct {
    bit         flt;
    logic [1:0] code;
    int         lat;
    int         ram;
    bit         ir;
    bit         mdrram;
    bit         mar;
    logic [5:0] opc;
    bit         ls;
  } exp_t;

  txn_t drv_q[$];
  exp_t exp_q[$];
  logic [5:0] legal_ops[8] = '{6'b000000, 6'b000001, 6'b000010, 6'b001001,
                               6'b001010, 6'b000100, 6'b000101, 6'b000110};

  mem_access_sequencer #(.TIMEOUT_CYC(TMO)) dut (
    .Clk(Clk), .Clr(Clr), .req_fetch(req_fetch), .req_ls(req_ls),
    .ls_op3(ls_op3), .addr_lo(addr_lo), .MFC(MFC),
    .grant_fetch(grant_fetch), .grant_ls(grant_ls), .MAR_Enable(MAR_Enable),
    .MDR_Enable(MDR_Enable), .MDR_Mux_select(MDR_Mux_select), .IR_Enable(IR_Enable),
    .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode), .busy_o(busy_o),
    .done_o(done_o), .fault_o(fault_o), .fault_code(fault_code)
  );

  assign all_outs = {grant_fetch, grant_ls, MAR_Enable, MDR_Enable, MDR_Mux_select,
                     IR_Enable, RAM_enable, RAM_OpCode, busy_o, done_o, fault_o, fault_code};

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level prediction: which path is taken and how many cycles each phase lasts.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    bit legal, word, half, store, mis;
    legal = 1'b0; word = 1'b0; half = 1'b0; store = 1'b0;
    case (t.op)
      6'b000000: begin legal = 1'b1; word = 1'b1; end
      6'b000100: begin legal = 1'b1; word = 1'b1; store = 1'b1; end
      6'b000010, 6'b001010: begin legal = 1'b1; half = 1'b1; end
      6'b000110: begin legal = 1'b1; half = 1'b1; store = 1'b1; end
      6'b000001, 6'b001001: legal = 1'b1;
      6'b000101: begin legal = 1'b1; store = 1'b1; end
      default: legal = 1'b0;
    endcase
    e = '{default: 0};
    e.ls  = t.ls;
    e.opc = t.op;
    mis = (word && t.addr != 2'b00) || (half && t.addr[0]);
    if (!legal) begin
      e.flt = 1'b1; e.code = 2'd3; e.lat = 1;
    end else if (mis) begin
      e.flt = 1'b1; e.code = 2'd1; e.lat = 2; e.mar = 1'b1;
    end else begin
      e.mar = 1'b1;
      if (t.wt >= TMO) begin
        e.flt = 1'b1; e.code = 2'd2; e.ram = TMO; e.lat = 1 + int'(store) + TMO + 1;
      end else if (store) begin
        e.ram = t.wt + 1; e.lat = 2 + (t.wt + 1) + 1;
      end else begin
        e.ram = t.wt + 2; e.lat = 1 + (t.wt + 1) + 1 + 1;
        e.ir = !t.ls; e.mdrram = t.ls;
      end
    end
    return e;
  endfunction

  task automatic add(input bit ls, input logic [5:0] op, input logic [1:0] addr,
                     input int wt, input bit drop);
    txn_t t;
    t.ls = ls; t.op = ls ? op : 6'b000000; t.addr = addr; t.wt = wt; t.drop = drop;
    drv_q.push_back(t);
  endtask

  // Raises all queued requests together (load/store queued first) and plays the RAM side.
  task automatic drive_round();
    int acc, guard;
    bit given;
    acc = 0; guard = 0; given = 1'b0;
    foreach (drv_q[i]) begin
      exp_q.push_back(model(drv_q[i]));
      if (drv_q[i].ls) begin req_ls = 1'b1; ls_op3 = drv_q[i].op; end
      else req_fetch = 1'b1;
    end
    while (drv_q.size() > 0 && guard < 300) begin
      addr_lo = drv_q[0].addr;
      @(negedge Clk);
      guard++;
      if (done_o || fault_o) begin
        if (drv_q[0].ls) req_ls = 1'b0; else req_fetch = 1'b0;
        drv_q.delete(0);
        acc = 0; given = 1'b0; MFC = 1'b0;
      end else begin
        if (drv_q[0].drop && busy_o) begin
          if (drv_q[0].ls) req_ls = 1'b0; else req_fetch = 1'b0;
        end
        if (RAM_enable && !given) begin
          if (acc == drv_q[0].wt) begin MFC = 1'b1; given = 1'b1; end
          else MFC = 1'b0;
          acc++;
        end else begin
          MFC = 1'b0;
        end
      end
    end
    chk("round_complete", drv_q.size(), 0);
    drv_q.delete();
    req_ls = 1'b0; req_fetch = 1'b0; MFC = 1'b0;
  endtask

  initial begin : monitor
    int lat, ram;
    bit ir, mdrram, mar, both, gls, post;
    logic [5:0] opc;
    logic [1:0] last_code;
    exp_t e;
    lat = 0; ram = 0; ir = 0; mdrram = 0; mar = 0; both = 0; gls = 0; post = 0;
    opc = 6'd0; last_code = 2'd0;
    forever begin
      @(negedge Clk);
      if (Clr) begin
        lat = 0; ram = 0; ir = 0; mdrram = 0; mar = 0; both = 0; post = 0; last_code = 2'd0;
      end else begin
        if (post) begin
          chk("busy_after_end", busy_o, 0);
          chk("fault_code_hold", fault_code, last_code);
          post = 0;
        end
        if (busy_o) begin
          if (lat == 0) gls = grant_ls;
          lat++;
          if (RAM_enable) begin ram++; opc = RAM_OpCode; end
          ir     |= IR_Enable;
          mdrram |= (MDR_Enable && MDR_Mux_select);
          mar    |= MAR_Enable;
          both   |= (grant_ls && grant_fetch);
        end
        if (done_o || fault_o) begin
          chk("expected_available", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("fault_pulse", fault_o, e.flt);
            chk("done_pulse", done_o, !e.flt);
            chk("fault_code", fault_code, e.code);
            chk("latency", lat, e.lat);
            chk("ram_cycles", ram, e.ram);
            chk("ir_load", ir, e.ir);
            chk("mdr_from_ram", mdrram, e.mdrram);
            chk("mar_load", mar, e.mar);
            chk("owner_ls", gls, e.ls);
            chk("grant_exclusive", both, 0);
            if (e.ram > 0) chk("ram_opcode", opc, e.opc);
            last_code = e.code;
          end
          post = 1;
          lat = 0; ram = 0; ir = 0; mdrram = 0; mar = 0; both = 0; opc = 6'd0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int guard, kind;
    txn_t a;
    Clr = 1'b1; req_fetch = 1'b0; req_ls = 1'b0; MFC = 1'b0; ls_op3 = 6'd0; addr_lo = 2'd0;
    #3;
    chk("reset_outputs", all_outs, 0);
    @(negedge Clk); @(negedge Clk);
    Clr = 1'b0;
    @(negedge Clk);
    chk("idle_after_reset", all_outs, 0);

    add(1'b0, 6'b000000, 2'b00, 0, 1'b0); drive_round();
    add(1'b1, 6'b000110, 2'b10, 3, 1'b0); drive_round();
    add(1'b1, 6'b000001, 2'b11, 0, 1'b0); add(1'b0, 6'b000000, 2'b00, 0, 1'b0); drive_round();
    add(1'b1, 6'b000000, 2'b01, 0, 1'b0); drive_round();
    add(1'b1, 6'b000011, 2'b00, 0, 1'b0); drive_round();
    add(1'b0, 6'b000000, 2'b00, 10, 1'b0); drive_round();
    add(1'b0, 6'b000000, 2'b00, 3, 1'b0); drive_round();
    add(1'b1, 6'b000100, 2'b00, 0, 1'b1); drive_round();

    // Clear in the middle of an access, then resume the still-held fetch.
    req_fetch = 1'b1; addr_lo = 2'b00; MFC = 1'b0;
    guard = 0;
    while (!RAM_enable && guard < 20) begin @(negedge Clk); guard++; end
    chk("reached_access", RAM_enable, 1);
    #2 Clr = 1'b1;
    #1 chk("clr_async_outputs", all_outs, 0);
    @(negedge Clk); @(negedge Clk);
    chk("clr_held_outputs", all_outs, 0);
    Clr = 1'b0;
    add(1'b0, 6'b000000, 2'b00, 0, 1'b0); drive_round();

    for (int r = 0; r < 60; r++) begin
      kind = $urandom_range(0, 3);
      ls_op3 = 6'($urandom);
      a.ls   = (kind != 0);
      a.op   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
      a.addr = 2'($urandom);
      a.wt   = $urandom_range(0, 5);
      a.drop = ($urandom_range(0, 3) == 0);
      add(a.ls, a.op, a.addr, a.wt, a.drop);
      if (kind == 3) add(1'b0, 6'b000000, 2'($urandom), $urandom_range(0, 5), 1'b0);
      drive_round();
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
